seg7_scan_driver: RTL and testbench

- Downstream of the reaction-time FSM/timer. Consumes the 14-bit elapsed-time value and the error flag.
- Converts the value to four BCD digits with a sequential double-dabble.
- Time-multiplexes the digits onto one shared 7-segment bus with per-digit anode enables, which feed the chip outputs.

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_scan_driver_if.sv | 21 ++
 rtl/bin2bcd_seq.sv | 48 ++++
 rtl/seg7_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment codes,
// conversion FSM states and the input saturation limit.
package seg7_pkg;

    localparam int MAX_VALUE = 9999;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights a segment
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_R   = 7'b0101111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    function automatic logic [13:0] sat_value(input logic [13:0] v);
        return (v > 14'(MAX_VALUE)) ? 14'(MAX_VALUE) : v;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/control inputs and display outputs of the scan driver, grouped as one bus.
interface seg7_scan_driver_if;
    logic [13:0] value_in;
    logic        load;
    logic        show_error;
    logic        blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  current_digit;
    logic        busy;

    modport master (
        output value_in, load, show_error, blank,
        input  seg, an, current_digit, busy
    );

    modport slave (
        input  value_in, load, show_error, blank,
        output seg, an, current_digit, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 14 shift/add iterations after start, done marks the
// cycle that performs the last one, so bcd is final on the following cycle.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        done,
    output logic [15:0] bcd
);

    logic [13:0] r_sr;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_run;
    logic [15:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_sr  <= bin;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            {r_bcd, r_sr} <= {w_adj, r_sr} << 1;
            r_cnt         <= r_cnt + 4'd1;
            if (r_cnt == 4'd13) r_run <= 1'b0;
        end
    end

    assign done = r_run && (r_cnt == 4'd13);
    assign bcd  = r_bcd;

endmodule

// File: rtl/seg7_scan_driver.sv
// Converts a binary ms value to BCD in the background and scans four digits
// onto a shared active-low 7-segment bus, with error and blank overrides.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter  int REFRESH_DIV = 10000,
    localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    bus
);

    conv_state_t r_state, w_state_nx;
    logic        w_start, w_commit, w_done;
    logic [13:0] w_start_val, w_in_sat;
    logic        r_pend, w_pend_nx;
    logic [13:0] r_pend_val, w_pend_val_nx;
    logic [15:0] w_bcd;
    logic [15:0] r_digits;

    logic [CNT_W-1:0] r_ref;
    logic [1:0]       r_cur;
    logic [3:0]       w_dig;
    logic             w_lz;
    logic [6:0]       w_seg_nx, r_seg;
    logic [3:0]       w_an_nx, r_an;

    assign w_in_sat = sat_value(bus.value_in);

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .bin   (w_start_val),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_digits   <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_pend     <= w_pend_nx;
            r_pend_val <= w_pend_val_nx;
            if (w_commit) r_digits <= w_bcd;
        end
    end

    // A load landing in COMMIT chains straight into the next conversion
    always_comb begin
        w_state_nx    = r_state;
        w_start       = 1'b0;
        w_start_val   = w_in_sat;
        w_commit      = 1'b0;
        w_pend_nx     = r_pend;
        w_pend_val_nx = r_pend_val;
        case (r_state)
            ST_IDLE: begin
                if (bus.load) begin
                    w_start    = 1'b1;
                    w_state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.load) begin
                    w_pend_nx     = 1'b1;
                    w_pend_val_nx = w_in_sat;
                end
                if (w_done) w_state_nx = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_commit = 1'b1;
                if (bus.load || r_pend) begin
                    w_start     = 1'b1;
                    w_start_val = bus.load ? w_in_sat : r_pend_val;
                    w_pend_nx   = 1'b0;
                    w_state_nx  = ST_SHIFT;
                end else begin
                    w_state_nx  = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref <= '0;
            r_cur <= '0;
        end else if (r_ref == CNT_W'(REFRESH_DIV - 1)) begin
            r_ref <= '0;
            r_cur <= r_cur + 2'd1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    assign w_dig = r_digits[{r_cur, 2'b00} +: 4];

    always_comb begin
        case (r_cur)
            2'd3:    w_lz = (r_digits[15:12] == 4'd0);
            2'd2:    w_lz = (r_digits[15:8] == 8'd0);
            2'd1:    w_lz = (r_digits[15:4] == 12'd0);
            default: w_lz = 1'b0;
        endcase
    end

    always_comb begin
        w_an_nx  = ~(4'b0001 << r_cur);
        w_seg_nx = w_lz ? SEG_OFF : seg_code(w_dig);
        if (bus.blank) begin
            w_an_nx  = 4'hF;
            w_seg_nx = SEG_OFF;
        end else if (bus.show_error) begin
            case (r_cur)
                2'd3:       w_seg_nx = SEG_E;
                2'd2, 2'd1: w_seg_nx = SEG_R;
                default:    w_seg_nx = SEG_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_OFF;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_seg_nx;
            r_an  <= w_an_nx;
        end
    end

    assign bus.seg           = r_seg;
    assign bus.an            = r_an;
    assign bus.current_digit = r_cur;
    assign bus.busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with REFRESH_DIV=4: an arithmetic display model
// predicts seg/an/current_digit/busy every cycle under directed and random input.
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int d);
        case (d)
            0: return 1;
            1: return 10;
            2: return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [6:0] code_of(input int n);
        case (n)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; default: return 7'h10;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input int v, input int d, input logic bl, input logic er);
        if (bl) return 7'h7F;
        if (er) begin
            if (d == 3) return 7'b0000110;
            if (d == 0) return 7'h7F;
            return 7'b0101111;
        end
        if (d > 0 && v < pow10(d)) return 7'h7F;
        return code_of((v / pow10(d)) % 10);
    endfunction

    function automatic int sat_of(input logic [13:0] v);
        return (int'(v) > 9999) ? 9999 : int'(v);
    endfunction

    // Model: a conversion started at edge E commits at E+15; loads during a
    // conversion (including its commit edge) queue one value, last one wins.
    int         m_tick, m_disp, m_val, m_pval, m_commit;
    logic       m_act, m_pend;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic [1:0] e_cd;
    logic       e_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tick <= 0; m_disp <= 0; m_val <= 0; m_pval <= 0; m_commit <= 0;
            m_act <= 1'b0; m_pend <= 1'b0;
            e_seg <= 7'h7F; e_an <= 4'hF; e_cd <= 2'd0; e_busy <= 1'b0;
        end else begin
            e_an   <= bus.blank ? 4'hF : ~(4'b0001 << ((m_tick / DIV) % 4));
            e_seg  <= ref_seg(m_disp, (m_tick / DIV) % 4, bus.blank, bus.show_error);
            e_cd   <= 2'(((m_tick + 1) / DIV) % 4);
            m_tick <= m_tick + 1;
            if (m_act && m_tick == m_commit) begin
                m_disp <= m_val;
                if (m_pend || bus.load) begin
                    m_val    <= bus.load ? sat_of(bus.value_in) : m_pval;
                    m_commit <= m_tick + 15;
                    m_pend   <= 1'b0;
                    e_busy   <= 1'b1;
                end else begin
                    m_act  <= 1'b0;
                    e_busy <= 1'b0;
                end
            end else if (m_act) begin
                if (bus.load) begin
                    m_pend <= 1'b1;
                    m_pval <= sat_of(bus.value_in);
                end
                e_busy <= 1'b1;
            end else if (bus.load) begin
                m_act    <= 1'b1;
                m_val    <= sat_of(bus.value_in);
                m_commit <= m_tick + 15;
                e_busy   <= 1'b1;
            end else begin
                e_busy <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        bus.load = 1'b0; bus.value_in = '0; bus.show_error = 1'b0; bus.blank = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.seg !== 7'h7F || bus.an !== 4'hF || bus.current_digit !== 2'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: seg=%h an=%h cd=%0d busy=%b want 7f f 0 0", bus.seg, bus.an, bus.current_digit, bus.busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (bus.seg !== e_seg || bus.an !== e_an || bus.current_digit !== e_cd || bus.busy !== e_busy) begin
                failures++;
                $display("FAIL idle_scan cyc%0d: seg=%h an=%h cd=%0d busy=%b want %h %h %0d %b",
                         i, bus.seg, bus.an, bus.current_digit, bus.busy, e_seg, e_an, e_cd, e_busy);
            end
        end
    endtask

    task automatic test_load(input logic [13:0] v, input string name);
        int nbusy = 0;
        bus.value_in = v; bus.load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.load = 1'b0;
            if (bus.busy === 1'b1) nbusy++;
            checks++;
            if (bus.seg !== e_seg || bus.an !== e_an || bus.current_digit !== e_cd || bus.busy !== e_busy) begin
                failures++;
                $display("FAIL %s cyc%0d: seg=%h an=%h cd=%0d busy=%b want %h %h %0d %b",
                         name, i, bus.seg, bus.an, bus.current_digit, bus.busy, e_seg, e_an, e_cd, e_busy);
            end
        end
        checks++;
        if (nbusy != 15) begin
            failures++;
            $display("FAIL %s_busy_len: got %0d cycles want 15", name, nbusy);
        end
    endtask

    task automatic test_back_to_back();
        int nbusy = 0;
        bus.value_in = 14'd7; bus.load = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.load = 1'b0;
            if (bus.busy === 1'b1) nbusy++;
            checks++;
            if (bus.seg !== e_seg || bus.an !== e_an || bus.current_digit !== e_cd || bus.busy !== e_busy) begin
                failures++;
                $display("FAIL back_to_back cyc%0d: seg=%h an=%h cd=%0d busy=%b want %h %h %0d %b",
                         i, bus.seg, bus.an, bus.current_digit, bus.busy, e_seg, e_an, e_cd, e_busy);
            end
            if (i == 2) begin bus.value_in = 14'd250; bus.load = 1'b1; end
        end
        checks++;
        if (nbusy != 30) begin
            failures++;
            $display("FAIL back_to_back_busy_len: got %0d cycles want 30", nbusy);
        end
    endtask

    task automatic test_error_blank();
        bus.value_in = 14'd1234; bus.load = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.load = 1'b0;
            checks++;
            if (bus.seg !== e_seg || bus.an !== e_an || bus.current_digit !== e_cd || bus.busy !== e_busy) begin
                failures++;
                $display("FAIL err_blank cyc%0d: seg=%h an=%h cd=%0d busy=%b want %h %h %0d %b",
                         i, bus.seg, bus.an, bus.current_digit, bus.busy, e_seg, e_an, e_cd, e_busy);
            end
            bus.show_error = (i >= 20 && i < 40) || (i >= 60 && i < 80);
            bus.blank      = (i >= 50 && i < 70);
        end
        bus.show_error = 1'b0; bus.blank = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++;
            if (bus.seg !== e_seg || bus.an !== e_an || bus.current_digit !== e_cd || bus.busy !== e_busy) begin
                failures++;
                $display("FAIL random cyc%0d: seg=%h an=%h cd=%0d busy=%b want %h %h %0d %b",
                         i, bus.seg, bus.an, bus.current_digit, bus.busy, e_seg, e_an, e_cd, e_busy);
            end
            bus.load       = ($urandom_range(0, 9) == 0);
            bus.value_in   = 14'($urandom_range(0, 16383));
            bus.show_error = ($urandom_range(0, 7) == 0);
            bus.blank      = ($urandom_range(0, 11) == 0);
        end
        bus.load = 1'b0; bus.show_error = 1'b0; bus.blank = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.value_in = 14'd1234; bus.load = 1'b1;
        repeat (6) begin
            @(negedge clk);
            bus.load = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.seg !== 7'h7F || bus.an !== 4'hF || bus.current_digit !== 2'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: seg=%h an=%h cd=%0d busy=%b want 7f f 0 0", bus.seg, bus.an, bus.current_digit, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (bus.seg !== e_seg || bus.an !== e_an || bus.current_digit !== e_cd || bus.busy !== e_busy) begin
                failures++;
                $display("FAIL after_reset cyc%0d: seg=%h an=%h cd=%0d busy=%b want %h %h %0d %b",
                         i, bus.seg, bus.an, bus.current_digit, bus.busy, e_seg, e_an, e_cd, e_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load(14'd1234, "load_1234");
        test_load(14'd10000, "load_sat");
        test_load(14'd0, "load_0");
        test_back_to_back();
        test_error_blank();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
